// File: rtl/conv_pkg.sv
// Shared constants and arithmetic helpers for the conv ReLU/pool stage.
package conv_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned POOL_STRIDE = 2;
    localparam int unsigned POOL_WIN    = 2;

    // Negative values (sign bit set) clamp to zero.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/conv_relu_pool_if.sv
// Conv result stream in, ReLU pass-through and pooled stream out.
interface conv_relu_pool_if #(
    parameter int unsigned DataWidth = 16
);
    logic                 i_sof;
    logic [DataWidth-1:0] i_conv_data;
    logic                 i_conv_valid;
    logic [DataWidth-1:0] o_relu_data;
    logic                 o_relu_valid;
    logic [DataWidth-1:0] o_pool_data;
    logic                 o_pool_valid;

    modport master (
        output i_sof, i_conv_data, i_conv_valid,
        input  o_relu_data, o_relu_valid, o_pool_data, o_pool_valid
    );

    modport slave (
        input  i_sof, i_conv_data, i_conv_valid,
        output o_relu_data, o_relu_valid, o_pool_data, o_pool_valid
    );
endinterface

// File: rtl/pool_line_buffer.sv
// One line of horizontal pooling maxima: single write port, combinational read.
module pool_line_buffer #(
    parameter int unsigned Depth     = 1,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrW     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [AddrW-1:0]     i_waddr,
    input  logic [DataWidth-1:0] i_wdata,
    input  logic [AddrW-1:0]     i_raddr,
    output logic [DataWidth-1:0] o_rdata_c
);

    logic [DataWidth-1:0] r_mem [Depth];

    // Address compare per entry keeps indexing legal for any depth, including 1.
    always_comb begin
        o_rdata_c = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (i_raddr == AddrW'(i)) o_rdata_c = r_mem[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
        end else if (i_we) begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (i_waddr == AddrW'(i)) r_mem[i] <= i_wdata;
            end
        end
    end

endmodule

// File: rtl/conv_relu_pool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-ordered conv map.
module conv_relu_pool
    import conv_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_W,
    parameter int unsigned OutWidth  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    conv_relu_pool_if.slave        io_bus
);

    localparam int unsigned HalfW = OutWidth / POOL_WIN;
    localparam int unsigned ColW  = $clog2(OutWidth);
    localparam int unsigned AddrW = (HalfW > 1) ? $clog2(HalfW) : 1;

    logic [ColW-1:0]      r_col;
    logic                 r_row_odd;
    logic [DataWidth-1:0] r_hold;
    logic [DataWidth-1:0] r_relu_data;
    logic                 r_relu_valid;
    logic [DataWidth-1:0] r_pool_data;
    logic                 r_pool_valid;

    logic                 w_resync;
    logic [ColW-1:0]      w_col;
    logic                 w_row_odd;
    logic                 w_last;
    logic [DataWidth-1:0] w_relu;
    logic [DataWidth-1:0] w_hmax;
    logic [AddrW-1:0]     w_lb_addr;
    logic [DataWidth-1:0] w_lb_rdata;
    logic                 w_lb_we;
    logic                 w_emit;

    // A valid start-of-frame beat overrides the counters to the frame origin.
    always_comb begin
        w_resync  = io_bus.i_sof & io_bus.i_conv_valid;
        w_col     = w_resync ? '0   : r_col;
        w_row_odd = w_resync ? 1'b0 : r_row_odd;
        w_last    = (w_col == ColW'(OutWidth - 1));
        w_relu    = DataWidth'(relu(DATA_W'(io_bus.i_conv_data)));
        w_hmax    = DataWidth'(smax(DATA_W'(r_hold), DATA_W'(w_relu)));
        w_lb_addr = AddrW'(w_col >> 1);
        w_lb_we   = io_bus.i_conv_valid & w_col[0] & ~w_row_odd;
        w_emit    = io_bus.i_conv_valid & w_col[0] &  w_row_odd;
    end

    pool_line_buffer #(
        .Depth     (HalfW),
        .DataWidth (DataWidth),
        .AddrW     (AddrW)
    ) u_lbuf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_lb_we),
        .i_waddr   (w_lb_addr),
        .i_wdata   (w_hmax),
        .i_raddr   (w_lb_addr),
        .o_rdata_c (w_lb_rdata)
    );

    // Position counters and horizontal hold; the dropped last column of an odd width leaves hold alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col     <= '0;
            r_row_odd <= 1'b0;
            r_hold    <= '0;
        end else if (io_bus.i_conv_valid) begin
            r_col     <= w_last ? '0 : w_col + ColW'(1);
            r_row_odd <= w_last ? ~w_row_odd : w_row_odd;
            if (!w_col[0] && !w_last) r_hold <= w_relu;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_relu_data  <= '0;
            r_relu_valid <= 1'b0;
            r_pool_data  <= '0;
            r_pool_valid <= 1'b0;
        end else begin
            r_relu_valid <= io_bus.i_conv_valid;
            r_pool_valid <= w_emit;
            if (io_bus.i_conv_valid) r_relu_data <= w_relu;
            if (w_emit) r_pool_data <= DataWidth'(smax(DATA_W'(w_lb_rdata), DATA_W'(w_hmax)));
        end
    end

    assign io_bus.o_relu_data  = r_relu_data;
    assign io_bus.o_relu_valid = r_relu_valid;
    assign io_bus.o_pool_data  = r_pool_data;
    assign io_bus.o_pool_valid = r_pool_valid;

endmodule
